maple_rx_frame_decoder: RTL and testbench

- Decodes Maple Bus two-wire (SDCKA/SDCKB) line activity into an 8-bit AXI-Stream byte stream, with TLAST on the final byte of each frame.
- Sits directly downstream of the bus pins and directly upstream of the RX FIFO.
- Recognises start, data and end patterns, and flags malformed frames.
- Every frame it starts emitting is always TLAST-terminated, including truncated frames.

---
 rtl/maple_rx_frame_decoder_if.sv | 17 +
 rtl/maple_rx_frame_decoder.sv | 231 +++++++++++++++++++++++
 tb/tb_maple_rx_frame_decoder.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/maple_rx_frame_decoder_if.sv
// maple_rx_frame_decoder_if: AXI-Stream byte channel carrying decoded Maple Bus frames.
//   tvalid : byte valid                  (master -> slave)
//   tdata  : byte, MSB received first    (master -> slave)
//   tstrb  : constant 1 while tvalid     (master -> slave)
//   tlast  : final byte of a frame       (master -> slave)
//   tready : downstream ready            (slave  -> master)
interface maple_rx_frame_decoder_if #(
    parameter int W = 8
);
    logic         tvalid;
    logic [W-1:0] tdata;
    logic         tstrb;
    logic         tlast;
    logic         tready;
    modport master (output tvalid, tdata, tstrb, tlast, input tready);
    modport slave  (input tvalid, tdata, tstrb, tlast, output tready);
endinterface

// File: rtl/maple_rx_frame_decoder.sv
// maple_rx_frame_decoder: decodes Maple Bus SDCKA/SDCKB line activity into a TLAST-terminated AXI-Stream byte stream.
//   aclk, aresetn      : clock, asynchronous active-low reset
//   sdcka_in, sdckb_in : raw bus lines (asynchronous, idle high)
//   enable             : permits new frame starts (gates IDLE -> START only)
//   m_axis             : 8-bit AXI-Stream master (tvalid/tdata/tstrb/tlast, tready)
//   receiving          : high from start detect until the state returns to IDLE or DROP
//   frame_error        : one-cycle pulse on framing, overflow or timeout error
//   byte_count         : bytes transferred in the current/last frame, cleared at start detect
module maple_rx_frame_decoder #(
    parameter int C_AXIS_TDATA_WIDTH = 8,
    parameter int SYNC_STAGES        = 2,
    parameter int TIMEOUT_CYCLES     = 4096
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     sdcka_in,
    input  logic                     sdckb_in,
    input  logic                     enable,
    maple_rx_frame_decoder_if.master m_axis,
    output logic                     receiving,
    output logic                     frame_error,
    output logic [10:0]              byte_count
);
    localparam int W  = C_AXIS_TDATA_WIDTH;
    localparam int BW = $clog2(W);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_END,
        S_FLUSH_OK,
        S_FLUSH_ERR,
        S_DROP
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sa_q, sa_d, sb_q, sb_d;
    logic                   a_prev_q, a_prev_d, b_prev_q, b_prev_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic                   phase_q, phase_d;
    logic [W-2:0]           sh_q, sh_d;
    logic [W-1:0]           pend_q, pend_d;
    logic                   pend_v_q, pend_v_d;
    logic [TW-1:0]          tcnt_q, tcnt_d;
    logic                   tvalid_q, tvalid_d;
    logic                   tlast_q, tlast_d;
    logic [W-1:0]           tdata_q, tdata_d;
    logic                   receiving_q, receiving_d;
    logic                   frame_error_q, frame_error_d;
    logic [10:0]            byte_count_q, byte_count_d;

    logic         a, b, a_fall, a_rise, b_fall, b_rise, any_chg, both_chg;
    logic         tmo, out_free, xfer;
    logic         err, load, load_last, byte_clr;
    logic [W-1:0] load_data, new_byte;

    assign a        = sa_q[SYNC_STAGES-1];
    assign b        = sb_q[SYNC_STAGES-1];
    assign a_fall   = a_prev_q & ~a;
    assign a_rise   = ~a_prev_q & a;
    assign b_fall   = b_prev_q & ~b;
    assign b_rise   = ~b_prev_q & b;
    assign any_chg  = (a ^ a_prev_q) | (b ^ b_prev_q);
    assign both_chg = (a ^ a_prev_q) & (b ^ b_prev_q);
    assign tmo      = (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) & ~any_chg;
    // The output register counts as free when it is empty or transferring this cycle.
    assign out_free = ~tvalid_q | m_axis.tready;
    assign xfer     = tvalid_q & m_axis.tready;
    // Phase A samples b on an a-fall, phase B samples a on a b-fall.
    assign new_byte = {sh_q, phase_q ? a : b};

    always_comb begin
        sa_d      = {sa_q[SYNC_STAGES-2:0], sdcka_in};
        sb_d      = {sb_q[SYNC_STAGES-2:0], sdckb_in};
        a_prev_d  = a;
        b_prev_d  = b;
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        phase_d   = phase_q;
        sh_d      = sh_q;
        pend_d    = pend_q;
        pend_v_d  = pend_v_q;
        err       = 1'b0;
        load      = 1'b0;
        load_last = 1'b0;
        load_data = pend_q;
        byte_clr  = 1'b0;
        // Inactivity counter runs inside a frame and restarts on any line edge.
        tcnt_d    = (state_q inside {S_START, S_DATA, S_END}) && !any_chg ? tcnt_q + 1'b1 : '0;
        case (state_q)
            S_IDLE: begin
                if (a_fall && b && enable) begin
                    state_d  = S_START;
                    cnt_d    = '0;
                    bit_d    = '0;
                    pend_v_d = 1'b0;
                    byte_clr = 1'b1;
                end
            end
            S_START: begin
                if (a_rise) begin
                    state_d = (cnt_q == 3'd4) ? S_DATA : S_IDLE;
                    phase_d = 1'b0;
                    bit_d   = '0;
                end else if (b_fall && !a) begin
                    cnt_d = cnt_q + 3'(cnt_q != 3'd7);
                end else if (tmo) begin
                    err     = 1'b1;
                    state_d = S_FLUSH_ERR;
                end
            end
            S_DATA: begin
                if (both_chg) begin
                    err     = 1'b1;
                    state_d = S_FLUSH_ERR;
                end else if (phase_q ? b_fall : a_fall) begin
                    sh_d    = new_byte[W-2:0];
                    bit_d   = bit_q + 1'b1;
                    phase_d = ~phase_q;
                    if (bit_q == BW'(W - 1)) begin
                        if (!pend_v_q) begin
                            pend_d   = new_byte;
                            pend_v_d = 1'b1;
                        end else if (out_free) begin
                            load   = 1'b1;
                            pend_d = new_byte;
                        end else begin
                            err     = 1'b1;
                            state_d = S_FLUSH_ERR;
                        end
                    end
                end else if (phase_q ? a_fall : b_fall) begin
                    // Clock edge of the wrong phase: in phase A it opens the end pattern.
                    err     = phase_q;
                    state_d = phase_q ? S_FLUSH_ERR : S_END;
                    cnt_d   = '0;
                end else if (tmo) begin
                    err     = 1'b1;
                    state_d = S_FLUSH_ERR;
                end
            end
            S_END: begin
                if (b_rise) begin
                    err     = !(cnt_q == 3'd2 && bit_q == '0 && pend_v_q);
                    state_d = err ? S_FLUSH_ERR : S_FLUSH_OK;
                end else if (a_fall && !b) begin
                    err     = (cnt_q == 3'd2);
                    state_d = err ? S_FLUSH_ERR : S_END;
                    cnt_d   = cnt_q + 1'b1;
                end else if (tmo) begin
                    err     = 1'b1;
                    state_d = S_FLUSH_ERR;
                end
            end
            S_FLUSH_OK, S_FLUSH_ERR: begin
                if (out_free) begin
                    load      = pend_v_q;
                    load_last = 1'b1;
                    pend_v_d  = 1'b0;
                    state_d   = (state_q == S_FLUSH_OK) ? S_IDLE : S_DROP;
                end
            end
            S_DROP: begin
                tcnt_d = (a && b) ? tcnt_q + 1'b1 : '0;
                if (a && b && tcnt_q == TW'(TIMEOUT_CYCLES - 1))
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        tvalid_d      = load | (tvalid_q & ~m_axis.tready);
        tdata_d       = load ? load_data : tdata_q;
        tlast_d       = load ? load_last : tlast_q;
        byte_count_d  = byte_clr ? '0 : byte_count_q + 11'(xfer);
        receiving_d   = (state_d != S_IDLE) && (state_d != S_DROP);
        frame_error_d = err;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= S_IDLE;
            sa_q          <= '1;
            sb_q          <= '1;
            a_prev_q      <= 1'b1;
            b_prev_q      <= 1'b1;
            cnt_q         <= '0;
            bit_q         <= '0;
            phase_q       <= 1'b0;
            sh_q          <= '0;
            pend_q        <= '0;
            pend_v_q      <= 1'b0;
            tcnt_q        <= '0;
            tvalid_q      <= 1'b0;
            tdata_q       <= '0;
            tlast_q       <= 1'b0;
            receiving_q   <= 1'b0;
            frame_error_q <= 1'b0;
            byte_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            sa_q          <= sa_d;
            sb_q          <= sb_d;
            a_prev_q      <= a_prev_d;
            b_prev_q      <= b_prev_d;
            cnt_q         <= cnt_d;
            bit_q         <= bit_d;
            phase_q       <= phase_d;
            sh_q          <= sh_d;
            pend_q        <= pend_d;
            pend_v_q      <= pend_v_d;
            tcnt_q        <= tcnt_d;
            tvalid_q      <= tvalid_d;
            tdata_q       <= tdata_d;
            tlast_q       <= tlast_d;
            receiving_q   <= receiving_d;
            frame_error_q <= frame_error_d;
            byte_count_q  <= byte_count_d;
        end
    end

    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tstrb  = tvalid_q;
    assign receiving     = receiving_q;
    assign frame_error   = frame_error_q;
    assign byte_count    = byte_count_q;
endmodule

// File: tb/tb_maple_rx_frame_decoder.sv
// tb_maple_rx_frame_decoder: directed frame vectors plus overflow, timeout and reset sequences.
module tb_maple_rx_frame_decoder;
    localparam int T   = 64;
    localparam int S   = 2;
    localparam int GAP = 4;

    typedef struct {
        int          pulses;
        bit          en;
        int          nbytes;
        logic [31:0] data;
        int          xbits;
        logic [3:0]  xdata;
        int          endp;
        int          exp_n;
        int          exp_err;
        int          exp_bc;
        bit          exp_rcv;
    } vec_t;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        a_l = 1'b1;
    logic        b_l = 1'b1;
    logic        enable = 1'b1;
    logic        receiving, frame_error;
    logic [10:0] byte_count;
    int          tests = 0;
    int          fails = 0;
    int          err_cnt = 0;
    int          ph = 0;
    bit          hold = 1'b0;
    bit          rcv_seen = 1'b0;
    logic [8:0]  held;
    logic [8:0]  q[$];

    maple_rx_frame_decoder_if axis();

    maple_rx_frame_decoder #(.SYNC_STAGES(S), .TIMEOUT_CYCLES(T)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .sdcka_in   (a_l),
        .sdckb_in   (b_l),
        .enable     (enable),
        .m_axis     (axis),
        .receiving  (receiving),
        .frame_error(frame_error),
        .byte_count (byte_count)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", nm, act, want);
        end
    endtask

    task automatic set_a(input logic v);
        @(negedge aclk);
        a_l = v;
        repeat (GAP) @(negedge aclk);
    endtask

    task automatic set_b(input logic v);
        @(negedge aclk);
        b_l = v;
        repeat (GAP) @(negedge aclk);
    endtask

    task automatic set_ready(input logic v);
        @(posedge aclk);
        #1 axis.tready = v;
    endtask

    task automatic send_bit(input logic v);
        if (ph == 0) begin
            if (!a_l) set_a(1'b1);
            if (b_l != v) set_b(v);
            set_a(1'b0);
            ph = 1;
        end else begin
            if (v) set_a(1'b1);
            if (!b_l) set_b(1'b1);
            set_b(1'b0);
            ph = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] x);
        for (int i = 7; i >= 0; i--) send_bit(x[i]);
    endtask

    task automatic start_pat(input int n);
        set_a(1'b0);
        for (int i = 0; i < n; i++) begin
            set_b(1'b0);
            if (i < n - 1) set_b(1'b1);
        end
        set_a(1'b1);
        ph = 0;
    endtask

    task automatic end_pat(input int n);
        if (!b_l) set_b(1'b1);
        set_b(1'b0);
        for (int i = 0; i < n; i++) begin
            if (!a_l) set_a(1'b1);
            set_a(1'b0);
        end
        set_b(1'b1);
        set_a(1'b1);
    endtask

    task automatic clear_obs();
        q.delete();
        err_cnt  = 0;
        rcv_seen = 1'b0;
    endtask

    // Observer: collects transfers, counts error pulses, and checks AXIS hold/tstrb rules.
    initial forever begin
        @(negedge aclk);
        if (!aresetn) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", 32'(axis.tvalid), 32'd1);
                chk("hold_data", 32'({axis.tlast, axis.tdata}), 32'(held));
            end
            if (axis.tvalid) chk("tstrb", 32'(axis.tstrb), 32'd1);
            if (frame_error) err_cnt++;
            if (receiving) rcv_seen = 1'b1;
            if (axis.tvalid && axis.tready) q.push_back({axis.tlast, axis.tdata});
            hold = axis.tvalid & ~axis.tready;
            held = {axis.tlast, axis.tdata};
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end

    initial begin
        vec_t vt[10];
        vec_t v;
        int   n;
        vt[0] = '{4, 1'b1, 4, 32'h05002001, 0, 4'h0, 2, 4, 0, 4, 1'b1};
        vt[1] = '{4, 1'b1, 1, 32'hA5000000, 0, 4'h0, 2, 1, 0, 1, 1'b1};
        vt[2] = '{4, 1'b0, 2, 32'h12340000, 0, 4'h0, 2, 0, 0, 1, 1'b0};
        vt[3] = '{3, 1'b1, 0, 32'h00000000, 0, 4'h0, 2, 0, 0, 0, 1'b1};
        vt[4] = '{4, 1'b1, 1, 32'h96000000, 4, 4'hA, 2, 1, 1, 1, 1'b1};
        vt[5] = '{5, 1'b1, 0, 32'h00000000, 0, 4'h0, 2, 0, 0, 0, 1'b1};
        vt[6] = '{4, 1'b1, 2, 32'hFF800000, 0, 4'h0, 2, 2, 0, 2, 1'b1};
        vt[7] = '{4, 1'b1, 1, 32'h3C000000, 0, 4'h0, 3, 1, 1, 1, 1'b1};
        vt[8] = '{4, 1'b1, 1, 32'hC3000000, 0, 4'h0, 1, 1, 1, 1, 1'b1};
        vt[9] = '{4, 1'b1, 0, 32'h00000000, 0, 4'h0, 2, 0, 1, 0, 1'b1};

        axis.tready = 1'b1;
        #1;
        chk("rst_tvalid", 32'(axis.tvalid), 32'd0);
        chk("rst_tdata", 32'(axis.tdata), 32'd0);
        chk("rst_tlast", 32'(axis.tlast), 32'd0);
        chk("rst_tstrb", 32'(axis.tstrb), 32'd0);
        chk("rst_receiving", 32'(receiving), 32'd0);
        chk("rst_frame_error", 32'(frame_error), 32'd0);
        chk("rst_byte_count", 32'(byte_count), 32'd0);
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        repeat (5) @(negedge aclk);

        for (int k = 0; k < 10; k++) begin
            v = vt[k];
            clear_obs();
            enable = v.en;
            start_pat(v.pulses);
            if (v.pulses == 4) begin
                for (int i = 0; i < v.nbytes; i++) send_byte(v.data[31-8*i -: 8]);
                for (int i = 0; i < v.xbits; i++) send_bit(v.xdata[3-i]);
                end_pat(v.endp);
            end else begin
                set_b(1'b1);
            end
            enable = 1'b1;
            repeat (T + 20) @(negedge aclk);
            chk($sformatf("v%0d_count", k), 32'(q.size()), 32'(v.exp_n));
            for (int i = 0; i < v.exp_n && i < q.size(); i++)
                chk($sformatf("v%0d_byte%0d", k, i), 32'(q[i]), 32'({1'(i == v.exp_n - 1), v.data[31-8*i -: 8]}));
            chk($sformatf("v%0d_errors", k), 32'(err_cnt), 32'(v.exp_err));
            chk($sformatf("v%0d_byte_count", k), 32'(byte_count), 32'(v.exp_bc));
            chk($sformatf("v%0d_rcv_seen", k), 32'(rcv_seen), 32'(v.exp_rcv));
            chk($sformatf("v%0d_rcv_end", k), 32'(receiving), 32'd0);
        end

        // Overflow: downstream stalled while the third byte completes.
        clear_obs();
        set_ready(1'b0);
        start_pat(4);
        send_byte(8'h05);
        send_byte(8'h00);
        chk("ovf_err_before", 32'(err_cnt), 32'd0);
        send_byte(8'h20);
        chk("ovf_err_at_third", 32'(err_cnt), 32'd1);
        send_byte(8'h01);
        end_pat(2);
        chk("ovf_stalled_count", 32'(q.size()), 32'd0);
        chk("ovf_stalled_data", 32'({axis.tvalid, axis.tlast, axis.tdata}), 32'h205);
        set_ready(1'b1);
        repeat (10) @(negedge aclk);
        start_pat(4);
        send_byte(8'h66);
        end_pat(2);
        chk("ovf_drop_ignores", 32'(q.size()), 32'd2);
        repeat (T + 20) @(negedge aclk);
        start_pat(4);
        send_byte(8'h77);
        end_pat(2);
        repeat (20) @(negedge aclk);
        chk("ovf_count", 32'(q.size()), 32'd3);
        if (q.size() == 3) begin
            chk("ovf_b0", 32'(q[0]), 32'h005);
            chk("ovf_b1", 32'(q[1]), 32'h100);
            chk("ovf_after_drop", 32'(q[2]), 32'h177);
        end
        chk("ovf_errors", 32'(err_cnt), 32'd1);

        // Timeout: lines freeze after one byte.
        clear_obs();
        start_pat(4);
        send_byte(8'h81);
        n = GAP;
        while (n < 500 && !frame_error) begin
            @(negedge aclk);
            n++;
        end
        chk("tmo_cycles", 32'(n), 32'(T + S + 1));
        repeat (5) @(negedge aclk);
        chk("tmo_count", 32'(q.size()), 32'd1);
        if (q.size() == 1) chk("tmo_byte", 32'(q[0]), 32'h181);
        chk("tmo_byte_count", 32'(byte_count), 32'd1);
        chk("tmo_receiving", 32'(receiving), 32'd0);
        set_a(1'b1);
        set_b(1'b1);
        repeat (T + 20) @(negedge aclk);
        chk("tmo_errors", 32'(err_cnt), 32'd1);

        // Asynchronous reset mid-byte with a byte held in the output register.
        clear_obs();
        set_ready(1'b0);
        start_pat(4);
        send_byte(8'hC3);
        send_byte(8'h3C);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        chk("pre_rst_out", 32'({axis.tvalid, axis.tdata}), 32'h1C3);
        chk("pre_rst_receiving", 32'(receiving), 32'd1);
        @(posedge aclk);
        #3 aresetn = 1'b0;
        #1;
        chk("mid_rst_tvalid", 32'(axis.tvalid), 32'd0);
        chk("mid_rst_tdata", 32'(axis.tdata), 32'd0);
        chk("mid_rst_tstrb", 32'(axis.tstrb), 32'd0);
        chk("mid_rst_receiving", 32'(receiving), 32'd0);
        chk("mid_rst_byte_count", 32'(byte_count), 32'd0);
        a_l = 1'b1;
        b_l = 1'b1;
        ph  = 0;
        axis.tready = 1'b1;
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        repeat (5) @(negedge aclk);
        clear_obs();
        start_pat(4);
        send_byte(8'h5A);
        send_byte(8'h0F);
        end_pat(2);
        repeat (20) @(negedge aclk);
        chk("post_rst_count", 32'(q.size()), 32'd2);
        if (q.size() == 2) begin
            chk("post_rst_b0", 32'(q[0]), 32'h05A);
            chk("post_rst_b1", 32'(q[1]), 32'h10F);
        end
        chk("post_rst_errors", 32'(err_cnt), 32'd0);
        chk("post_rst_byte_count", 32'(byte_count), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
